// File: rtl/spi_rec_sequencer.sv
// SPI receive sequencer: reads one 5-byte frame from an SPI master, one byte at a time,
// and writes the bytes to receive-buffer addresses 3..7. The frame is then held until
// the consumer accepts it.
// Optional feature: define SPI_TIMEOUT_EN to abort a byte request that waits too long
// for spi_ack (goes to ERR and sets the sticky timeout_err flag).

module spi_rec_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       spi_req,
  output logic [2:0] spi_byte_idx,
  input  logic       spi_ack,
  input  logic [7:0] spi_data_in,
  output logic       buffer_en,
  output logic [4:0] addr,
  output logic [7:0] data_rec,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       timeout_err
);

  localparam logic [2:0] LastIdx  = 3'd4;
  localparam logic [4:0] BaseAddr = 5'd3;

  // Reject out-of-range timeouts at elaboration.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

`ifdef SPI_TIMEOUT_EN
  typedef enum logic [2:0] {StIdle, StReq, StStore, StDone, StErr} state_e;
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
`else
  typedef enum logic [2:0] {StIdle, StReq, StStore, StDone} state_e;
`endif

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       terr_q, terr_d;
`ifdef SPI_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  // State and datapath registers; reset forces IDLE with cleared index and data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      data_q  <= 8'd0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      terr_q  <= terr_d;
    end
  end

`ifdef SPI_TIMEOUT_EN
  // Wait counter for the current byte request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Next-state logic: sequence REQ/STORE pairs for bytes 0..4, then hold in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    terr_d  = terr_q;
`ifdef SPI_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          idx_d   = 3'd0;
          terr_d  = 1'b0;
`ifdef SPI_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end
      end
      StReq: begin
        // An ack in the same cycle as the timeout wins.
        if (spi_ack) begin
          data_d  = spi_data_in;
          state_d = StStore;
        end else begin
`ifdef SPI_TIMEOUT_EN
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == TimeoutLast) begin
            state_d = StErr;
            terr_d  = 1'b1;
          end
`endif
        end
      end
      StStore: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = StReq;
`ifdef SPI_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end
      end
      StDone: begin
        // start in the same cycle as frame_ready is dropped.
        if (frame_ready) begin
          state_d = StIdle;
        end
      end
`ifdef SPI_TIMEOUT_EN
      StErr: begin
        state_d = StIdle;
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from registered state only, so reset reaches them immediately.
  always_comb begin
    busy         = (state_q != StIdle);
    spi_req      = (state_q == StReq);
    spi_byte_idx = idx_q;
    buffer_en    = (state_q == StStore);
    addr         = BaseAddr;
    if (state_q == StStore) begin
      addr = BaseAddr + {2'b00, idx_q};
    end
    data_rec     = data_q;
    frame_valid  = (state_q == StDone);
    timeout_err  = terr_q;
  end

endmodule

// File: tb/tb_spi_rec_sequencer.sv
// Self-checking bench for spi_rec_sequencer: a frame-progress model checked every cycle,
// plus directed scenarios with hand-computed cycle/address/data expectations.

module tb_spi_rec_sequencer;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       spi_ack = 1'b0;
  logic       frame_ready = 1'b0;
  logic [7:0] data_base = 8'hA1;
  logic [7:0] spi_data_in;
  logic       busy, spi_req, buffer_en, frame_valid, timeout_err;
  logic [2:0] spi_byte_idx;
  logic [4:0] addr;
  logic [7:0] data_rec;

  spi_rec_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .spi_req      (spi_req),
    .spi_byte_idx (spi_byte_idx),
    .spi_ack      (spi_ack),
    .spi_data_in  (spi_data_in),
    .buffer_en    (buffer_en),
    .addr         (addr),
    .data_rec     (data_rec),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Slave returns 0xA1 + byte index.
  assign spi_data_in = data_base + {5'd0, spi_byte_idx};

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SPI slave responder: 0 = ack always high, 1 = ack in 8th request cycle, 2 = never.
  int ack_mode = 0;
  int req_age = 0;
  always @(negedge clk) begin
    if (spi_req) req_age <= req_age + 1;
    else         req_age <= 0;
    case (ack_mode)
      0:       spi_ack <= 1'b1;
      1:       spi_ack <= spi_req && (req_age == 7);
      default: spi_ack <= 1'b0;
    endcase
  end

  // Model: frame progress p. -1 idle; 2k = requesting byte k; 2k+1 = writing byte k;
  // 10 = frame held; 11 = aborted.
  int         m_p = -1;
  int         m_wait = 0;
  logic [7:0] m_data = 8'd0;
  logic       m_terr = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_p    <= -1;
      m_data <= 8'd0;
      m_terr <= 1'b0;
      m_wait <= 0;
    end else if (m_p == -1) begin
      if (start) begin
        m_p    <= 0;
        m_terr <= 1'b0;
        m_wait <= 0;
      end
    end else if (m_p == 11) begin
      m_p <= -1;
    end else if (m_p == 10) begin
      if (frame_ready) m_p <= -1;
    end else if (m_p % 2 == 1) begin
      m_p    <= m_p + 1;
      m_wait <= 0;
    end else if (spi_ack) begin
      m_data <= spi_data_in;
      m_p    <= m_p + 1;
    end else begin
      m_wait <= m_wait + 1;
`ifdef SPI_TIMEOUT_EN
      if (m_wait + 1 == int'(TO)) begin
        m_p    <= 11;
        m_terr <= 1'b1;
      end
`endif
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      begin
        logic e_req, e_wr;
        int   e_addr;
        e_req  = (m_p >= 0) && (m_p < 10) && (m_p % 2 == 0);
        e_wr   = (m_p >= 0) && (m_p < 10) && (m_p % 2 == 1);
        e_addr = e_wr ? 3 + m_p / 2 : 3;
        check("model_busy", busy, m_p != -1);
        check("model_spi_req", spi_req, e_req);
        check("model_buffer_en", buffer_en, e_wr);
        check("model_addr", addr, e_addr);
        check("model_frame_valid", frame_valid, m_p == 10);
        check("model_timeout_err", timeout_err, m_terr);
        check("model_data_rec", data_rec, m_data);
        if (e_req) check("model_spi_byte_idx", spi_byte_idx, m_p / 2);
      end
    end
  end

  // Scenario bookkeeping, sampled 1 time unit after each falling edge.
  int         cyc = 0;
  int         wr_cnt, req_cnt, idx_chg, frames, fv_cycles, first_req, first_fv;
  int         wr_cyc[$];
  logic [4:0] wr_addr[$];
  logic [7:0] wr_dat[$];
  logic       req_prev, fv_prev;
  logic [2:0] idx_prev;

  task automatic clear_stats();
    wr_cnt = 0; req_cnt = 0; idx_chg = 0; frames = 0; fv_cycles = 0;
    first_req = -1; first_fv = -1;
    wr_cyc.delete(); wr_addr.delete(); wr_dat.delete();
    req_prev = 1'b0; fv_prev = 1'b0; idx_prev = 3'd0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    cyc++;
    if (buffer_en) begin
      wr_cnt++;
      wr_cyc.push_back(cyc);
      wr_addr.push_back(addr);
      wr_dat.push_back(data_rec);
    end
    if (spi_req) begin
      req_cnt++;
      if (first_req < 0) first_req = cyc;
      if (req_prev && spi_byte_idx != idx_prev) idx_chg++;
    end
    if (frame_valid) begin
      fv_cycles++;
      if (!fv_prev) frames++;
      if (first_fv < 0) first_fv = cyc;
    end
    req_prev = spi_req;
    idx_prev = spi_byte_idx;
    fv_prev  = frame_valid;
  endtask

  task automatic start_frame();
    clear_stats();
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_fv(input int budget);
    int n = 0;
    while (!frame_valid && n < budget) begin
      tick();
      n++;
    end
    check("wait_frame_valid", frame_valid, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_spi_req"}, spi_req, 1'b0);
    check({tag, "_buffer_en"}, buffer_en, 1'b0);
    check({tag, "_frame_valid"}, frame_valid, 1'b0);
    check({tag, "_timeout_err"}, timeout_err, 1'b0);
    check({tag, "_addr"}, addr, 5'd3);
    check({tag, "_spi_byte_idx"}, spi_byte_idx, 3'd0);
    check({tag, "_data_rec"}, data_rec, 8'd0);
  endtask

  initial begin
    clear_stats();
    #1 rst = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Nominal frame, then hold frame_valid for 21 cycles before accepting.
    ack_mode = 0;
    start_frame();
    while (cyc < 31) tick();
    check("nom_first_req_cycle", first_req, 1);
    check("nom_write_count", wr_cnt, 5);
    for (int i = 0; i < 5; i++) begin
      if (i < wr_cyc.size()) begin
        check($sformatf("nom_wr%0d_cycle", i), wr_cyc[i], 2 + 2 * i);
        check($sformatf("nom_wr%0d_addr", i), wr_addr[i], 3 + i);
        check($sformatf("nom_wr%0d_data", i), wr_dat[i], 8'hA1 + i);
      end
    end
    check("nom_first_fv_cycle", first_fv, 11);
    check("backpressure_fv_cycles", fv_cycles, 21);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check("nom_idle_after_ready", busy, 1'b0);
    check("nom_data_rec_last", data_rec, 8'hA5);

    // Slow slave with start pulses in REQ and DONE.
    ack_mode = 1;
    data_base = 8'h10;
    start_frame();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_fv(100);
    check("slow_first_fv_cycle", first_fv, 46);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("slow_still_done", frame_valid, 1'b1);
    frame_ready = 1'b1;
    start = 1'b1;
    tick();
    frame_ready = 1'b0;
    start = 1'b0;
    check("slow_idle_after_ready", busy, 1'b0);
    tick();
    check("slow_start_dropped", busy, 1'b0);
    check("slow_write_count", wr_cnt, 5);
    check("slow_req_cycles", req_cnt, 40);
    check("slow_idx_stable", idx_chg, 0);
    check("slow_frame_count", frames, 1);
    check("slow_last_data", data_rec, 8'h14);

    // Reset during the STORE of byte 2.
    ack_mode = 0;
    data_base = 8'hA1;
    start_frame();
    for (int n = 0; n < 20 && !(buffer_en && addr == 5'd5); n++) tick();
    check("rst_reached_store2", {buffer_en, addr}, {1'b1, 5'd5});
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("rst_no_more_writes", wr_cnt, 3);
    check("rst_idle", busy, 1'b0);
    start_frame();
    wait_fv(40);
    check("rst_new_frame_writes", wr_cnt, 5);
    if (wr_addr.size() == 5) check("rst_new_frame_last_addr", wr_addr[4], 5'd7);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;

`ifdef SPI_TIMEOUT_EN
    // Timeout: request for 4 cycles, one ERR cycle, then IDLE with the flag kept.
    ack_mode = 2;
    start_frame();
    while (cyc < 4) tick();
    check("to_req_cycles", req_cnt, 4);
    tick();
    check("to_err_spi_req", spi_req, 1'b0);
    check("to_err_busy", busy, 1'b1);
    check("to_err_flag", timeout_err, 1'b1);
    tick();
    check("to_idle_busy", busy, 1'b0);
    check("to_idle_flag", timeout_err, 1'b1);
    ack_mode = 0;
    start_frame();
    check("to_flag_cleared", timeout_err, 1'b0);
    wait_fv(40);
    check("to_recover_writes", wr_cnt, 5);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
`else
    // Without the timeout feature a missing ack waits indefinitely.
    ack_mode = 2;
    start_frame();
    while (cyc < 30) tick();
    check("nto_req_cycles", req_cnt, 30);
    check("nto_still_req", spi_req, 1'b1);
    check("nto_flag", timeout_err, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("nto_reset_recovers", busy, 1'b0);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
